// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
// - stage_state_e : occupancy state of a two-entry skid stage; the encoding
//                   equals the number of held entries so it can drive occ directly.
// - OCC_W         : width of the occupancy output.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Occupancy is the state encoding itself; kept as a function so callers
  // do not depend on that coincidence.
  function automatic logic [OCC_W-1:0] occ_of(stage_state_e s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Ports:
//   clk   in          clock, rising edge
//   rst   in          synchronous active-low reset (count -> 0)
//   inc   in          count one event this cycle
//   clr   in          clear to zero; wins over inc
//   count out [CNT_W] current count, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a two-entry skid buffer.
// Carries one flat WIDTH-bit payload under a valid/ready handshake. The skid
// entry absorbs the one payload that can arrive while downstream stalls, which
// lets in_ready_o depend only on registered state.
// Ports:
//   clk          in           clock, rising edge
//   rst          in           synchronous active-low reset
//   flush_i      in           squash all held entries
//   in_valid_i   in           upstream payload valid
//   in_ready_o   out          stage can accept (from state register)
//   in_data_i    in  [WIDTH]  upstream payload
//   out_valid_o  out          payload valid toward downstream
//   out_ready_i  in           downstream accepts
//   out_data_o   out [WIDTH]  head payload
//   occ_o        out [2]      entries held: 0, 1 or 2
//   cnt_clr_i    in           clear stall counter
//   stall_cnt_o  out [CNT_W]  saturating count of valid-but-not-ready cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [OCC_W-1:0] occ_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             acc, take;
  logic             load_main_in, load_main_skid, load_skid_in;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign occ_o       = occ_of(state_q);

  assign acc  = in_valid_i & in_ready_o;
  assign take = out_valid_o & out_ready_i;

  // Next state and data-register load enables.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_i) begin
      // Anything accepted this cycle is squashed; a take still completes.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            load_main_in = 1'b1;
            state_d      = HALF;
          end
        end
        HALF: begin
          if (acc && take) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (take) begin
            state_d      = EMPTY;
          end
        end
        FULL: begin
          // in_ready_o is low here, so acc cannot occur.
          if (take) begin
            load_main_skid = 1'b1;
            state_d        = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: the payload registers are reset as well, so out_data_o reads zero
  // after reset instead of stale data; flush leaves them alone since
  // out_valid_o already masks them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_data_i;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_data_i;
      end
    end
  end

  // Back-pressure statistics: the head is valid but downstream refuses it.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid_o & ~out_ready_i),
    .clr  (cnt_clr_i),
    .count(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Two instances share all inputs:
// the default configuration and one with a 4-bit stall counter for saturation.
// A queue-based model (entries held, FIFO order, capacity two) predicts every
// output; hand-written table vectors pin down the multi-cycle corner cases.
module tb_pipe_stage_skid;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o, in_ready_4;
  logic [W-1:0]  in_data_i;
  logic          out_valid_o, out_valid_4;
  logic          out_ready_i;
  logic [W-1:0]  out_data_o, out_data_4;
  logic [1:0]    occ_o, occ_4;
  logic          cnt_clr_i;
  logic [15:0]   stall_cnt_o;
  logic [3:0]    stall_cnt_4;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .occ_o(occ_o), .cnt_clr_i(cnt_clr_i), .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_skid #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_4), .in_data_i(in_data_i),
    .out_valid_o(out_valid_4), .out_ready_i(out_ready_i), .out_data_o(out_data_4),
    .occ_o(occ_4), .cnt_clr_i(cnt_clr_i), .stall_cnt_o(stall_cnt_4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: held payloads in order, plus the two stall counters.
  logic [W-1:0] q[$];
  int unsigned  m_cnt16 = 0;
  int unsigned  m_cnt4  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances with the model (pre-edge view).
  task automatic check_model(input string tag);
    check({tag, " in_ready"},  W'(in_ready_o),  W'(q.size() < 2));
    check({tag, " out_valid"}, W'(out_valid_o), W'(q.size() > 0));
    check({tag, " occ"},       W'(occ_o),       W'(q.size()));
    if (q.size() > 0) check({tag, " out_data"}, out_data_o, q[0]);
    check({tag, " stall_cnt"}, W'(stall_cnt_o), W'(m_cnt16));
    check({tag, " occ4"},      W'(occ_4),       W'(q.size()));
    if (q.size() > 0) check({tag, " out_data4"}, out_data_4, q[0]);
    check({tag, " stall_cnt4"}, W'(stall_cnt_4), W'(m_cnt4));
  endtask

  // One clock: drive inputs, check the model, clock, advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                       input logic f, input logic c);
    bit acc, take, stall;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    cnt_clr_i   = c;
    check_model("model");
    acc   = v && (q.size() < 2);
    take  = r && (q.size() > 0);
    stall = !r && (q.size() > 0);
    @(posedge clk); #1;
    if (take) void'(q.pop_front());
    if (f) q.delete();
    else if (acc) q.push_back(d);
    if (c) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else if (stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 32'hDEAD_BEEF;
    out_ready_i = 1'b0;
    flush_i    = 1'b0;
    cnt_clr_i  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
    q.delete();
    m_cnt16 = 0;
    m_cnt4  = 0;
    check("reset occ",       W'(occ_o),       0);
    check("reset out_valid", W'(out_valid_o), 0);
    check("reset in_ready",  W'(in_ready_o),  1);
    check("reset out_data",  out_data_o,      0);
    check("reset stall_cnt", W'(stall_cnt_o), 0);
    check("reset stall_cnt4", W'(stall_cnt_4), 0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         f;
    logic         c;
    logic [1:0]   occ;
    logic         rdy;
    logic         val;
    logic         chk_d;
    logic [W-1:0] data;
    int unsigned  cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Expected values are the outputs after the clock edge of that row.
    //          v  d    r  f  c  occ rdy val chk data cnt
    tbl[0]  = '{1, 'hA, 0, 0, 0, 1,  1,  1,  1,  'hA, 0};
    tbl[1]  = '{1, 'hB, 0, 0, 0, 2,  0,  1,  1,  'hA, 1};
    tbl[2]  = '{1, 'hC, 0, 0, 0, 2,  0,  1,  1,  'hA, 2};
    tbl[3]  = '{1, 'hC, 0, 0, 0, 2,  0,  1,  1,  'hA, 3};
    tbl[4]  = '{1, 'hC, 1, 0, 0, 1,  1,  1,  1,  'hB, 3};
    tbl[5]  = '{1, 'hC, 1, 0, 0, 1,  1,  1,  1,  'hC, 3};
    tbl[6]  = '{0, 'h0, 1, 0, 0, 0,  1,  0,  0,  'h0, 3};
    tbl[7]  = '{1, 'hA, 0, 0, 0, 1,  1,  1,  1,  'hA, 3};
    tbl[8]  = '{1, 'hB, 0, 0, 0, 2,  0,  1,  1,  'hA, 4};
    tbl[9]  = '{1, 'hD, 0, 1, 0, 0,  1,  0,  0,  'h0, 5};
    tbl[10] = '{0, 'h0, 1, 0, 0, 0,  1,  0,  0,  'h0, 5};
    tbl[11] = '{0, 'h0, 1, 0, 1, 0,  1,  0,  0,  'h0, 0};
    tbl[12] = '{1, 'hE, 0, 0, 0, 1,  1,  1,  1,  'hE, 0};
    tbl[13] = '{0, 'h0, 0, 0, 0, 1,  1,  1,  1,  'hE, 1};
    tbl[14] = '{0, 'h0, 0, 0, 1, 1,  1,  1,  1,  'hE, 0};
    tbl[15] = '{0, 'h0, 1, 0, 0, 0,  1,  0,  0,  'h0, 0};

    do_reset(2);

    // Back-pressure, release, flush and counter-clear vectors.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].c);
      check($sformatf("vec%0d occ", i),       W'(occ_o),       W'(tbl[i].occ));
      check($sformatf("vec%0d in_ready", i),  W'(in_ready_o),  W'(tbl[i].rdy));
      check($sformatf("vec%0d out_valid", i), W'(out_valid_o), W'(tbl[i].val));
      if (tbl[i].chk_d) check($sformatf("vec%0d out_data", i), out_data_o, tbl[i].data);
      check($sformatf("vec%0d stall_cnt", i), W'(stall_cnt_o), W'(tbl[i].cnt));
    end

    // Streaming: one transfer per cycle, one cycle of latency.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      check($sformatf("stream%0d data", i), out_data_o, W'(i));
      check($sformatf("stream%0d occ", i),  W'(occ_o),  1);
    end
    check("stream stall_cnt", W'(stall_cnt_o), 0);
    cycle(1'b0, 'x, 1'b1, 1'b0, 1'b0);
    check("stream drained occ", W'(occ_o), 0);

    // Saturation of the 4-bit counter, then clear while still stalled.
    cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 'x, 1'b0, 1'b0, 1'b0);
    check("sat stall_cnt4", W'(stall_cnt_4), 15);
    check("sat stall_cnt16", W'(stall_cnt_o), 20);
    check("sat data held", out_data_o, 32'h55);
    cycle(1'b0, 'x, 1'b0, 1'b0, 1'b1);
    check("clr during stall", W'(stall_cnt_4), 0);
    check("clr during stall16", W'(stall_cnt_o), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      logic v, r, f, c;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 65);
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 127) == 0);
      cycle(v, v ? W'($urandom) : 'x, r, f, c);
    end
    check_model("rand end");

    // Reset in the middle of a transfer discards everything.
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    check("pre-reset occ", W'(occ_o), 2);
    do_reset(1);
    cycle(1'b0, 'x, 1'b1, 1'b0, 1'b0);
    check("post-reset occ", W'(occ_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
